// File: rtl/avalon_mem_pkg.sv
// avalon_mem_pkg: shared types and constants for the avalon_mem_slave block.
//   state_e      : responder FSM states (IDLE, BUSY, ACK)
//   WORD_W/BE_W  : data word and byte-enable widths
//   LFSR_*       : seed and tap mask of the optional random wait-state LFSR
//   merge_bytes  : byte-lane merge of write data into an existing word
//   lfsr_next    : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package avalon_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Bits 15,13,12,10 correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old_word,
                                                    input logic [WORD_W-1:0] new_word,
                                                    input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avalon_mem_slave_if.sv
// avalon_mem_slave_if: Avalon-MM memory port between the core (master) and
// the memory responder (slave).
//   address/read/write/writedata/byteenable : master -> slave request
//   waitrequest/readdata                    : slave -> master response
interface avalon_mem_slave_if;
  import avalon_mem_pkg::*;

  logic [31:0]       address;
  logic              read;
  logic              write;
  logic [WORD_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [WORD_W-1:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/avalon_mem_slave_wait_state_gen.sv
// wait_state_gen: wait-state counter for avalon_mem_slave.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse when a new request is accepted (loads the counter)
//   done       : high in the last wait cycle (next cycle is the ACK cycle)
// Optional feature macro RANDOM_WAIT_EN adds 0..3 extra wait states per
// request, drawn from a 16-bit LFSR that advances once per accepted request.
module wait_state_gen
  import avalon_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] load_s;

`ifdef RANDOM_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;

  // LFSR register: steps once for each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Next LFSR value and randomised load value.
  always_comb begin
    lfsr_d = lfsr_q;
    if (start) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
    load_s = WAIT_LD + {3'b000, lfsr_q[1:0]};
  end
`else
  assign load_s = WAIT_LD;
`endif

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 5'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Load on start, otherwise count down to zero. done fires when the counter
  // is about to reach zero so the ACK lands WAIT+1 cycles after acceptance;
  // a zero load completes in the acceptance cycle itself.
  always_comb begin
    count_d = count_q;
    done    = 1'b0;
    if (start) begin
      count_d = load_s;
      done    = (load_s == 5'd0);
    end else if (count_q != 5'd0) begin
      count_d = count_q - 5'd1;
      done    = (count_q == 5'd1);
    end else begin
      count_d = count_q;
      done    = 1'b0;
    end
  end

endmodule

// File: rtl/avalon_mem_slave.sv
// avalon_mem_slave: Avalon-MM single-port word RAM responder with wait states.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : avalon_mem_slave_if.slave (address, read, write, writedata,
//                byteenable in; waitrequest, readdata out)
// BASE_ADDR maps to word 0; addresses wrap modulo 2**DEPTH_LOG2 words.
// Optional feature macro RANDOM_WAIT_EN (in wait_state_gen) randomises waits.
module avalon_mem_slave
  import avalon_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  avalon_mem_slave_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0]     mem_q [DEPTH];
  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  op_write_q, op_write_d;
  logic [WORD_W-1:0]     readdata_q, readdata_d;

  logic        req_s;
  logic        start_s;
  logic        done_s;
  logic [31:0] offset_s;
  logic        unused_s;

  assign req_s    = bus.read | bus.write;
  assign start_s  = (state_q == IDLE) & req_s;
  assign offset_s = bus.address - BASE_ADDR;
  assign unused_s = ^{offset_s[31:DEPTH_LOG2+2], offset_s[1:0]};

  wait_state_gen #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_s),
    .done  (done_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a request dropped while BUSY aborts the transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = done_s ? ACK : BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!req_s) begin
          state_d = IDLE;
        end else if (done_s) begin
          state_d = ACK;
        end else begin
          state_d = BUSY;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: stall any request except in the single ACK cycle.
  always_comb begin
    bus.waitrequest = req_s & (state_q != ACK);
    bus.readdata    = readdata_q;
  end

  // Request latch and read capture. read&write together is a write.
  always_comb begin
    idx_d      = start_s ? offset_s[DEPTH_LOG2+1:2] : idx_q;
    op_write_d = start_s ? bus.write : op_write_q;
    readdata_d = readdata_q;
    if ((state_d == ACK) && !op_write_d) begin
      readdata_d = mem_q[idx_d];
    end else begin
      readdata_d = readdata_q;
    end
  end

  // Request latch and readdata registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      op_write_q <= 1'b0;
      readdata_q <= 32'h0;
    end else begin
      idx_q      <= idx_d;
      op_write_q <= op_write_d;
      readdata_q <= readdata_d;
    end
  end

  // Memory array (not reset): writes commit at the end of the ACK cycle using
  // the writedata/byteenable presented in that cycle.
  always_ff @(posedge clk) begin
    if ((state_q == ACK) && op_write_q) begin
      mem_q[idx_q] <= merge_bytes(mem_q[idx_q], bus.writedata, bus.byteenable);
    end
  end

endmodule

// File: tb/tb_avalon_mem_slave.sv
module tb_avalon_mem_slave;
  import avalon_mem_pkg::*;

  localparam int          DL2   = 10;
  localparam int          DEPTH = 1 << DL2;
  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          WAITC = 2;
`ifdef RANDOM_WAIT_EN
  localparam int          MAXW  = WAITC + 4;
`else
  localparam int          MAXW  = WAITC + 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_mem_slave_if bus();

  avalon_mem_slave #(
    .DEPTH_LOG2  (DL2),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          wcnt  = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd;
  logic [31:0] exp_q [$];

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts stall cycles of the current request and, at every ACK,
  // pops the expected readdata and checks both data and latency.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.read | bus.write) begin
        if (bus.waitrequest) begin
          wcnt++;
        end else begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_ack: got ACK expected none at %0t", $time);
          end else begin
            check("readdata", bus.readdata, exp_q.pop_front());
          end
          n_vec++;
          if (wcnt < WAITC + 1 || wcnt > MAXW) begin
            n_err++;
            $display("FAIL wait_span: got %0d expected %0d..%0d at %0t", wcnt, WAITC + 1, MAXW, $time);
          end
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // One transfer; addr2/wd2 are driven from the second cycle on (the DUT must
  // keep the latched address and use the ACK-cycle writedata).
  task automatic xfer(input logic [31:0] addr, input logic rd, input logic wr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] addr2, input logic [31:0] wd2);
    int idx;
    logic got;
    idx = word_of(addr);
    if (wr) begin
      ref_mem[idx] = merge(ref_mem[idx], wd2, be);
    end else begin
      last_rd = ref_mem[idx];
    end
    exp_q.push_back(last_rd);
    @(negedge clk);
    bus.address = addr; bus.read = rd; bus.write = wr;
    bus.writedata = wd; bus.byteenable = be;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      #3;
      if (!bus.waitrequest) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        if (c == 0) begin
          bus.address = addr2; bus.writedata = wd2;
        end
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: got no ACK expected ACK within 40 cycles at %0t", $time);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic rd_word(input logic [31:0] addr);
    xfer(addr, 1'b1, 1'b0, 32'h0, 4'h0, addr, 32'h0);
  endtask

  task automatic wr_word(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
    xfer(addr, 1'b0, 1'b1, d, be, addr, d);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  initial begin
    bus.address = 32'h0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = 32'h0; bus.byteenable = 4'h0;
    last_rd = 32'h0;
    repeat (3) @(negedge clk);
    #3;
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_waitreq", {31'h0, bus.waitrequest}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload, reset-vector read, byte-lane merge, wrap and low address bits.
    wr_word(BASE, 32'h24020005, 4'hF);
    wr_word(BASE + 32'd4, 32'h11223344, 4'hF);
    rd_word(BASE);
    wr_word(BASE + 32'd4, 32'hDEADBEEF, 4'b0101);
    rd_word(BASE + 32'd4);
    rd_word(BASE + 32'd4096);
    rd_word(BASE + 32'd7);
    idle();

    // read & write together behave as a write; readdata must not move.
    wr_word(BASE + 32'd8, 32'h55555555, 4'hF);
    xfer(BASE + 32'd8, 1'b1, 1'b1, 32'h0000FFFF, 4'hF, BASE + 32'd8, 32'h0000FFFF);
    rd_word(BASE + 32'd8);

    // Inputs changing while BUSY; zero byteenable write.
    xfer(BASE, 1'b1, 1'b0, 32'h0, 4'h0, BASE + 32'd4, 32'h0);
    xfer(BASE + 32'd12, 1'b0, 1'b1, 32'h11111111, 4'hF, BASE + 32'd16, 32'h22222222);
    rd_word(BASE + 32'd12);
    wr_word(BASE + 32'd12, 32'hFFFFFFFF, 4'h0);
    rd_word(BASE + 32'd12);
    idle();

    // Abort: write dropped while BUSY must not reach the array.
    wr_word(BASE + 32'd24, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    bus.address = BASE + 32'd24; bus.read = 1'b0; bus.write = 1'b1;
    bus.writedata = 32'h0; bus.byteenable = 4'hF;
    @(negedge clk);
    bus.write = 1'b0;
    rd_word(BASE + 32'd24);
    idle();

    // Reset during BUSY of a write: discarded, readdata cleared.
    wr_word(BASE + 32'd20, 32'hA5A50F0F, 4'hF);
    @(negedge clk);
    bus.address = BASE + 32'd20; bus.read = 1'b0; bus.write = 1'b1;
    bus.writedata = 32'hFFFFFFFF; bus.byteenable = 4'hF;
    @(negedge clk);
    rst_n = 1'b0; bus.write = 1'b0;
    #3;
    check("rst_mid_readdata", bus.readdata, 32'h0);
    bus.read = 1'b1;
    #1;
    check("waitreq_in_reset", {31'h0, bus.waitrequest}, 32'h1);
    @(negedge clk);
    bus.read = 1'b0; rst_n = 1'b1;
    last_rd = 32'h0;
    wr_word(BASE + 32'd28, 32'h0BADF00D, 4'hF);
    rd_word(BASE + 32'd20);
    idle();

    // Randomised back-to-back traffic over 64 words with aliased addresses.
    for (int i = 0; i < 64; i++)
      wr_word(BASE + 32'(4 * i) + ($urandom << 12) + 32'($urandom_range(0, 3)), $urandom, 4'hF);
    for (int i = 0; i < 100; i++) begin
      int          op;
      logic [31:0] a;
      logic [31:0] d;
      op = $urandom_range(0, 3);
      a  = BASE + 32'(4 * $urandom_range(0, 63)) + ($urandom << 12) + 32'($urandom_range(0, 3));
      d  = $urandom;
      if (op < 2) rd_word(a);
      else if (op == 2) wr_word(a, d, 4'($urandom_range(0, 15)));
      else xfer(a, 1'b1, 1'b1, d, 4'($urandom_range(0, 15)), a, d);
    end
    idle();

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
